// File: rtl/audio_pkg.sv
// audio_pkg: shared audio constants, stereo pair type and slot decoding helper.
package audio_pkg;

  localparam int unsigned PCM_WIDTH  = 24;
  localparam int unsigned SLOT_BITS  = 32;
  localparam int unsigned FRAME_BITS = 64;
  localparam int unsigned CNT_W      = $clog2(FRAME_BITS);
  localparam int unsigned SLOT_W     = $clog2(SLOT_BITS);

  typedef struct packed {
    logic [PCM_WIDTH-1:0] left;
    logic [PCM_WIDTH-1:0] right;
  } stereo_pair_t;

  // True when a frame bit count falls on a data bit of its slot (slot bits 1..PCM_WIDTH);
  // slot bit 0 is the I2S one-bit delay, the tail of the slot is zero padding.
  function automatic logic slot_has_data(input logic [CNT_W-1:0] cnt);
    logic [SLOT_W-1:0] sb;
    sb = cnt[SLOT_W-1:0];
    return (sb != '0) && ({{(32-SLOT_W){1'b0}}, sb} <= PCM_WIDTH);
  endfunction

endpackage

// File: rtl/i2s_master_tx_if.sv
// i2s_master_tx_if: push/pop handshake between the I2S transmitter and its sample FIFO.
//   master : push, pop, flush, push_data out; full, empty, pop_data in (transmitter side)
//   slave  : the mirror image (FIFO side)
interface i2s_master_tx_if;
  import audio_pkg::*;

  logic         push;
  logic         pop;
  logic         flush;
  logic         full;
  logic         empty;
  stereo_pair_t push_data;
  stereo_pair_t pop_data;

  modport master (output push, pop, flush, push_data,
                  input  full, empty, pop_data);
  modport slave  (input  push, pop, flush, push_data,
                  output full, empty, pop_data);
endinterface

// File: rtl/stereo_sample_fifo.sv
// stereo_sample_fifo: DEPTH-entry FIFO of stereo pairs (DEPTH a power of 2, >= 2).
//   clk, rst_n : clock, asynchronous active-low reset (pointers only)
//   bus        : slave side of i2s_master_tx_if (push/pop/flush/full/empty/data)
// A push on a full FIFO is accepted only when a pop happens in the same cycle.
module stereo_sample_fifo
  import audio_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  i2s_master_tx_if.slave  bus
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  stereo_pair_t mem_q [DEPTH];
  logic         empty, full;
  logic         do_push, do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign bus.empty    = empty;
  assign bus.full     = full;
  assign bus.pop_data = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    do_pop   = bus.pop && !empty && !bus.flush;
    do_push  = bus.push && (!full || do_pop) && !bus.flush;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= bus.push_data;
  end

endmodule

// File: rtl/i2s_master_tx.sv
// i2s_master_tx: I2S master transmitter, 24-bit samples in 32-bit slots, 64-bit frames.
//   clk, reset_n           : system clock, asynchronous active-low reset
//   audio_en               : run enable; low flushes and idles everything
//   l_data_en / l_data     : left sample strobe / sample (held until the right arrives)
//   r_data_en / r_data     : right sample strobe / sample (pushes the stereo pair)
//   bclk, lrclk, s_data    : I2S bit clock, word select, serial data
//   i2s_valid              : current frame carries FIFO data
//   underrun / overrun     : sticky: empty FIFO at frame start / pair dropped on full FIFO
module i2s_master_tx
  import audio_pkg::*;
#(
  parameter int unsigned BCLK_DIV   = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 audio_en,
  input  logic                 l_data_en,
  input  logic                 r_data_en,
  input  logic [PCM_WIDTH-1:0] l_data,
  input  logic [PCM_WIDTH-1:0] r_data,
  output logic                 bclk,
  output logic                 lrclk,
  output logic                 s_data,
  output logic                 i2s_valid,
  output logic                 underrun,
  output logic                 overrun
);

  localparam int unsigned      DIV_W    = $clog2(BCLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);
  localparam int unsigned      SH_W     = 2 * PCM_WIDTH;

  logic [DIV_W-1:0]     div_cnt_q, div_cnt_d;
  logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic                 bclk_q, bclk_d;
  logic                 lrclk_q, lrclk_d;
  logic                 s_data_q, s_data_d;
  logic                 valid_q, valid_d;
  logic                 underrun_q, underrun_d;
  logic                 overrun_q, overrun_d;
  logic                 en_q, en_d;
  logic [PCM_WIDTH-1:0] l_hold_q, l_hold_d;
  logic [SH_W-1:0]      shift_q, shift_d;

  logic                 bclk_fall, frame_start, push, pop;
  stereo_pair_t         push_data;

  i2s_master_tx_if fifo_bus ();

  stereo_sample_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (reset_n),
    .bus   (fifo_bus.slave)
  );

  assign fifo_bus.push      = push;
  assign fifo_bus.pop       = pop;
  assign fifo_bus.flush     = !audio_en;
  assign fifo_bus.push_data = push_data;

  always_comb begin
    div_cnt_d   = div_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    bclk_d      = bclk_q;
    lrclk_d     = lrclk_q;
    s_data_d    = s_data_q;
    valid_d     = valid_q;
    underrun_d  = underrun_q;
    overrun_d   = overrun_q;
    shift_d     = shift_q;
    l_hold_d    = l_hold_q;
    en_d        = audio_en;
    bclk_fall   = 1'b0;
    frame_start = 1'b0;
    push        = 1'b0;
    pop         = 1'b0;
    push_data   = '{left: l_hold_q, right: r_data};

    if (!audio_en) begin
      div_cnt_d  = '0;
      bit_cnt_d  = '0;
      bclk_d     = 1'b0;
      lrclk_d    = 1'b0;
      s_data_d   = 1'b0;
      valid_d    = 1'b0;
      underrun_d = 1'b0;
      overrun_d  = 1'b0;
      shift_d    = '0;
      l_hold_d   = '0;
    end else begin
      // A left strobe coincident with the right strobe bypasses the holding register.
      if (l_data_en) begin
        l_hold_d       = l_data;
        push_data.left = l_data;
      end
      push = r_data_en;

      if (div_cnt_q == DIV_LAST) begin
        div_cnt_d = '0;
        bclk_d    = ~bclk_q;
        bclk_fall = bclk_q;
      end else begin
        div_cnt_d = div_cnt_q + 1'b1;
      end

      // Outputs present the bit of the count being entered on each falling edge.
      if (bclk_fall) begin
        bit_cnt_d = bit_cnt_q + 1'b1;
        lrclk_d   = bit_cnt_d[CNT_W-1];
        s_data_d  = 1'b0;
        if (bit_cnt_d == '0) begin
          frame_start = 1'b1;
        end else if (slot_has_data(bit_cnt_d)) begin
          s_data_d = shift_q[SH_W-1];
          shift_d  = {shift_q[SH_W-2:0], 1'b0};
        end
      end

      // The first clk with audio_en high opens bit count 0 of the first frame.
      if (!en_q) frame_start = 1'b1;

      if (frame_start) begin
        pop     = !fifo_bus.empty;
        shift_d = fifo_bus.empty ? '0 : fifo_bus.pop_data;
        valid_d = !fifo_bus.empty;
        if (fifo_bus.empty) underrun_d = 1'b1;
      end

      if (push && fifo_bus.full && !pop) overrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      bclk_q     <= 1'b0;
      lrclk_q    <= 1'b0;
      s_data_q   <= 1'b0;
      valid_q    <= 1'b0;
      underrun_q <= 1'b0;
      overrun_q  <= 1'b0;
      en_q       <= 1'b0;
      l_hold_q   <= '0;
      shift_q    <= '0;
    end else begin
      div_cnt_q  <= div_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      bclk_q     <= bclk_d;
      lrclk_q    <= lrclk_d;
      s_data_q   <= s_data_d;
      valid_q    <= valid_d;
      underrun_q <= underrun_d;
      overrun_q  <= overrun_d;
      en_q       <= en_d;
      l_hold_q   <= l_hold_d;
      shift_q    <= shift_d;
    end
  end

  assign bclk      = bclk_q;
  assign lrclk     = lrclk_q;
  assign s_data    = s_data_q;
  assign i2s_valid = valid_q;
  assign underrun  = underrun_q;
  assign overrun   = overrun_q;

endmodule
